// File: rtl/hazard_sched_ctrl.sv
// hazard_sched_ctrl: stall/flush/forward control for the 5-stage RV32 pipeline with debug halt/step
module hazard_sched_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             LoadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic             halt_req,
  input  logic             step_req,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, STEP} state_t;
  state_t state, nextState;
  logic lwStall, memWait;
  logic sF, sD, sE, sM, fD, fE, fW, hlt;
  logic [1:0] fwdA, fwdB;
  logic [TMO_W-1:0] waitCnt;
  assign lwStall = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign memWait = MemReqM && !MemAckM;
  assign fwdA = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
  assign fwdB = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  always_comb begin
    {sF, sD, sE, sM, fD, fE, fW} = '0;
    nextState = state;
    hlt = state == HALTED || state == STEP;
    // a pending memory access freezes everything regardless of FSM state
    if (memWait) {sF, sD, sE, sM, fW} = '1;
    else if (state == HALTED) {sF, sD, fE} = '1;
    else if (PCSrcE) {fD, fE} = '1;
    else if (lwStall) {sF, sD, fE} = '1;
    case (state)
      RUN:      nextState = memWait ? MEM_WAIT : halt_req ? HALTED : RUN;
      MEM_WAIT: nextState = memWait ? MEM_WAIT : RUN;
      HALTED:   nextState = memWait ? HALTED : !halt_req ? RUN : step_req ? STEP : HALTED;
      STEP:     nextState = (memWait || sD) ? STEP : HALTED;
      default:  nextState = RUN;
    endcase
  end
  assign ForwardAE = rst ? fwdA : 2'b00;
  assign ForwardBE = rst ? fwdB : 2'b00;
  assign StallF = rst & sF;
  assign StallD = rst & sD;
  assign StallE = rst & sE;
  assign StallM = rst & sM;
  assign FlushD = rst & fD;
  assign FlushE = rst & fE;
  assign FlushW = rst & fW;
  assign halted = rst & hlt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      waitCnt   <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= !memWait ? '0 : (waitCnt == TMO_W'(MEM_TIMEOUT)) ? waitCnt : waitCnt + 1'b1;
      if (memWait && waitCnt == TMO_W'(MEM_TIMEOUT - 1)) mem_err <= 1'b1;
      if (sF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// tb_hazard_sched_ctrl: scoreboard bench for hazard_sched_ctrl forwarding, stalls, timeout and debug FSM
module tb_hazard_sched_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM, halt_req, step_req;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted, mem_err;
  logic [15:0] stall_cnt;
  logic [12:0] outVec, expQ[$];
  string tagQ[$];
  int checks = 0, errors = 0;
  localparam logic [12:0] IDLE = 13'h000, LU = 13'h188, MW = 13'h1E4, BR = 13'h018;
  localparam logic [12:0] HLT = 13'h18A, HFLAG = 13'h002, ERR = 13'h001;
  hazard_sched_ctrl dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .LoadE(LoadE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .halt_req(halt_req), .step_req(step_req), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD),
    .FlushE(FlushE), .FlushW(FlushW), .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );
  assign outVec = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted, mem_err};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic clearIn();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM, halt_req, step_req} = '0;
  endtask
  // expectation is queued with the stimulus, compared once outputs settle, then the clock advances
  task automatic cyc(input string tag, input logic [12:0] exp);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge clk);
    chk(tagQ.pop_front(), 32'(outVec), 32'(expQ.pop_front()));
    @(posedge clk);
    #1;
  endtask
  initial begin
    clearIn();
    LoadE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; MemReqM = 1'b1;
    cyc("reset_gate", IDLE);
    chk("reset_cnt", 32'(stall_cnt), 0);
    rst = 1'b1;
    clearIn();
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5;
    cyc("fwd_m_prio", 13'h1000);
    RdM = 5'd0;
    cyc("fwd_w", 13'h0800);
    RdM = 5'd5; Rs2E = 5'd5;
    cyc("fwd_mm", 13'h1400);
    RegWriteM = 1'b0;
    cyc("fwd_ww", 13'h0A00);
    RdW = 5'd0; Rs1E = 5'd0;
    cyc("fwd_zero", IDLE);
    clearIn();
    LoadE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    cyc("lw_stall", LU);
    chk("lw_cnt", 32'(stall_cnt), 1);
    LoadE = 1'b0;
    cyc("lw_one", IDLE);
    LoadE = 1'b1; PCSrcE = 1'b1;
    cyc("lw_branch", BR);
    PCSrcE = 1'b0; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    cyc("lw_x0", IDLE);
    chk("lw_cnt2", 32'(stall_cnt), 1);
    clearIn();
    MemReqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PCSrcE = (i == 2);
      cyc("mem_wait", MW);
    end
    MemAckM = 1'b1; PCSrcE = 1'b0;
    cyc("mem_ack", IDLE);
    clearIn();
    cyc("mem_run", IDLE);
    chk("mem_cnt", 32'(stall_cnt), 5);
    MemReqM = 1'b1;
    for (int i = 0; i < 200; i++) cyc("tmo_wait", MW);
    MemAckM = 1'b1;
    cyc("tmo_err", ERR);
    clearIn();
    cyc("tmo_sticky", ERR);
    chk("tmo_cnt", 32'(stall_cnt), 205);
    halt_req = 1'b1;
    cyc("halt_req", ERR);
    cyc("halted", HLT | ERR);
    step_req = 1'b1;
    cyc("step_req", HLT | ERR);
    step_req = 1'b0;
    cyc("step", HFLAG | ERR);
    cyc("step_back", HLT | ERR);
    halt_req = 1'b0;
    cyc("unhalt", HLT | ERR);
    cyc("run_again", ERR);
    chk("halt_cnt", 32'(stall_cnt), 209);
    MemReqM = 1'b1;
    cyc("rst_wait0", MW | ERR);
    cyc("rst_wait1", MW | ERR);
    rst = 1'b0;
    #1;
    chk("async_out", 32'(outVec), 0);
    chk("async_cnt", 32'(stall_cnt), 0);
    #1 rst = 1'b1;
    clearIn();
    cyc("post_rst", IDLE);
    LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    cyc("post_rst_lw", LU);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
